ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arb_pkg.sv | 16 +
 rtl/ahb_rr_picker.sv | 39 +++
 rtl/ahb_arbiter.sv | 106 ++++++++++
 tb/tb_ahb_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared types and constants for the AHB arbiter
package ahb_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam int MAX_MASTERS = 16;

endpackage

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - rotating priority encoder, first set bit at or after a start pointer
module ahb_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  input  logic [3:0]   i_start,
  output logic [N-1:0] o_onehot,
  output logic [3:0]   o_index,
  output logic         o_valid
);

  // Rotated view: bit k is the request of master (start + k) mod N.
  // Doubling the vector makes the wrap free; the start pointer is always < N.
  logic [N-1:0] w_rot;
  assign w_rot = N'({i_req, i_req} >> i_start);

  // Pick the first rotated position that requests and map it back to a master index.
  always_comb begin
    logic [4:0] sum;
    o_valid  = 1'b0;
    o_index  = 4'd0;
    o_onehot = '0;
    sum      = 5'd0;
    for (int k = 0; k < N; k++) begin
      if (!o_valid && w_rot[k]) begin
        sum = {1'b0, i_start} + 5'(k);
        if (sum >= 5'(N)) begin
          sum = sum - 5'(N);
        end
        o_valid = 1'b1;
        o_index = sum[3:0];
      end
    end
    if (o_valid) begin
      o_onehot = N'(1) << o_index;
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - AHB bus arbiter with fixed/round-robin policy, lock hold and split masking
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int        NUM_MASTERS    = 4,
  parameter arb_mode_e ARB_MODE       = ARB_RR,
  parameter int        DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hrst,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  input  logic [NUM_MASTERS-1:0] hsplit,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [3:0]             hmaster,
  output logic                   hmastlock
);

  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [3:0]             DEF_IDX   = 4'(DEFAULT_MASTER);
  localparam logic [3:0]             LAST_IDX  = 4'(NUM_MASTERS - 1);

  logic [NUM_MASTERS-1:0] r_hgrant;
  logic [3:0]             r_owner;
  logic [3:0]             r_hmaster;
  logic                   r_hmastlock;
  logic [NUM_MASTERS-1:0] r_split_mask;
  logic [3:0]             r_last_owner;

  logic                   w_owner_lock;
  logic                   w_split_evt;
  logic [NUM_MASTERS-1:0] w_split_set;
  logic                   w_arb;
  logic [NUM_MASTERS-1:0] w_elig;
  logic [3:0]             w_rr_start;
  logic [3:0]             w_start;
  logic [NUM_MASTERS-1:0] w_pick_onehot;
  logic [3:0]             w_pick_idx;
  logic                   w_pick_valid;

  // The grant is one-hot, so masking hlock with it selects the owner's lock bit.
  assign w_owner_lock = |(hlock & r_hgrant);

  // A SPLIT is signalled in the first (hready low) cycle of the two-cycle response.
  assign w_split_evt = !hready && (hresp == HRESP_SPLIT);

  // Decode the address-phase owner into the split bit to set this cycle.
  always_comb begin
    w_split_set = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_split_set[i] = w_split_evt && (r_hmaster == 4'(i));
    end
  end

  // A split forces re-arbitration even mid-lock; otherwise wait for hready with no lock.
  assign w_arb  = w_split_evt || (hready && !w_owner_lock);
  assign w_elig = hbusreq & ~(r_split_mask | w_split_set);

  assign w_rr_start = (r_last_owner == LAST_IDX) ? 4'd0 : r_last_owner + 4'd1;
  assign w_start    = (ARB_MODE == ARB_RR) ? w_rr_start : 4'd0;

  ahb_rr_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .i_req    (w_elig),
    .i_start  (w_start),
    .o_onehot (w_pick_onehot),
    .o_index  (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  // Grant, address-phase owner and split mask registers.
  always_ff @(posedge hclk) begin
    if (!hrst) begin
      r_hgrant     <= DEF_GRANT;
      r_owner      <= DEF_IDX;
      r_hmaster    <= DEF_IDX;
      r_hmastlock  <= 1'b0;
      r_split_mask <= '0;
      r_last_owner <= DEF_IDX;
    end else begin
      r_split_mask <= (r_split_mask & ~hsplit) | w_split_set;
      if (w_arb) begin
        if (w_pick_valid) begin
          r_hgrant     <= w_pick_onehot;
          r_owner      <= w_pick_idx;
          r_last_owner <= w_pick_idx;
        end else begin
          r_hgrant <= DEF_GRANT;
          r_owner  <= DEF_IDX;
        end
      end
      if (hready) begin
        r_hmaster   <= r_owner;
        r_hmastlock <= w_owner_lock;
      end
    end
  end

  assign hgrant    = r_hgrant;
  assign hmaster   = r_hmaster;
  assign hmastlock = r_hmastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - scoreboard bench for ahb_arbiter, round-robin and fixed instances
module tb_ahb_arbiter;
  import ahb_arb_pkg::*;

  typedef struct {
    logic [3:0] g;
    logic [3:0] m;
    logic       l;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] lk;
    logic       rdy;
    logic [1:0] resp;
    logic [3:0] spl;
  } stim_t;

  logic       hclk = 1'b0;
  logic       hrst = 1'b0;
  logic [3:0] hbusreq = '0;
  logic [3:0] hlock = '0;
  logic       hready = 1'b1;
  logic [1:0] hresp = HRESP_OKAY;
  logic [3:0] hsplit = '0;
  logic [3:0] g0, m0, g1, m1;
  logic       l0, l1;

  int vec = 0;
  int err = 0;
  exp_t sb[$];

  int         m_g[2];
  int         m_m[2];
  logic       m_l[2];
  logic [3:0] m_s[2];
  int         m_last[2];
  bit         m_rr[2]  = '{1'b1, 1'b0};
  int         m_def[2] = '{0, 2};

  always #5 hclk = ~hclk;

  ahb_arbiter #(.NUM_MASTERS(4), .ARB_MODE(ARB_RR), .DEFAULT_MASTER(0)) u_rr (
    .hclk(hclk), .hrst(hrst), .hbusreq(hbusreq), .hlock(hlock), .hready(hready),
    .hresp(hresp), .hsplit(hsplit), .hgrant(g0), .hmaster(m0), .hmastlock(l0)
  );

  ahb_arbiter #(.NUM_MASTERS(4), .ARB_MODE(ARB_FIXED), .DEFAULT_MASTER(2)) u_fix (
    .hclk(hclk), .hrst(hrst), .hbusreq(hbusreq), .hlock(hlock), .hready(hready),
    .hresp(hresp), .hsplit(hsplit), .hgrant(g1), .hmaster(m1), .hmastlock(l1)
  );

  function automatic stim_t mk(input logic rst, input logic [3:0] req, input logic [3:0] lk,
                               input logic rdy, input logic [1:0] resp, input logic [3:0] spl);
    stim_t s;
    s.rst = rst; s.req = req; s.lk = lk; s.rdy = rdy; s.resp = resp; s.spl = spl;
    return s;
  endfunction

  // Drive one cycle, predict both instances from the behavioural model, push, clock.
  task automatic step(input stim_t s);
    exp_t       e;
    int         old_g;
    int         pick;
    bit         found;
    bit         split_evt;
    logic [3:0] set_b;
    logic [3:0] elig;
    logic [3:0] one4;
    hrst = s.rst; hbusreq = s.req; hlock = s.lk;
    hready = s.rdy; hresp = s.resp; hsplit = s.spl;
    one4 = 4'd1;
    for (int i = 0; i < 2; i++) begin
      if (!s.rst) begin
        m_g[i] = m_def[i]; m_m[i] = m_def[i]; m_l[i] = 1'b0;
        m_s[i] = 4'b0; m_last[i] = m_def[i];
      end else begin
        old_g = m_g[i];
        split_evt = !s.rdy && (s.resp == HRESP_SPLIT);
        set_b = 4'b0;
        if (split_evt) set_b[m_m[i]] = 1'b1;
        if (split_evt || (s.rdy && !s.lk[old_g])) begin
          elig = s.req & ~(m_s[i] | set_b);
          found = 0;
          for (int k = 0; k < 4; k++) begin
            pick = m_rr[i] ? (m_last[i] + 1 + k) % 4 : k;
            if (!found && elig[pick]) begin
              found = 1;
              m_g[i] = pick;
            end
          end
          if (found) m_last[i] = m_g[i];
          else m_g[i] = m_def[i];
        end
        m_s[i] = (m_s[i] & ~s.spl) | set_b;
        if (s.rdy) begin
          m_m[i] = old_g;
          m_l[i] = s.lk[old_g];
        end
      end
      e.g = one4 << m_g[i];
      e.m = 4'(m_m[i]);
      e.l = m_l[i];
      sb.push_back(e);
    end
    @(posedge hclk);
    @(negedge hclk);
  endtask

  task automatic test_reset;
    stim_t v[$];
    exp_t  e0, e1;
    for (int j = 0; j < 3; j++) v.push_back(mk(0, 4'b1111, 4'b1111, 1, HRESP_SPLIT, 4'b1111));
    v.push_back(mk(1, 4'b0000, 4'b0000, 1, HRESP_OKAY, 4'b0000));
    foreach (v[j]) begin
      step(v[j]);
      e0 = sb.pop_front(); e1 = sb.pop_front();
      vec++;
      if ({g0, m0, l0} !== {e0.g, e0.m, e0.l}) begin
        err++;
        $display("FAIL reset rr step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g0, m0, l0, e0.g, e0.m, e0.l);
      end
      vec++;
      if ({g1, m1, l1} !== {e1.g, e1.m, e1.l}) begin
        err++;
        $display("FAIL reset fix step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g1, m1, l1, e1.g, e1.m, e1.l);
      end
      vec++;
      if ({g0, m0, l0} !== {4'b0001, 4'd0, 1'b0}) begin
        err++;
        $display("FAIL reset_const step %0d: got g=%b m=%0d l=%b want g=0001 m=0 l=0", j, g0, m0, l0);
      end
    end
  endtask

  task automatic test_rr_rotate;
    stim_t      v[$];
    exp_t       e0, e1;
    logic [3:0] rot[8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int j = 0; j < 8; j++) v.push_back(mk(1, 4'b1111, 4'b0000, 1, HRESP_OKAY, 4'b0000));
    foreach (v[j]) begin
      step(v[j]);
      e0 = sb.pop_front(); e1 = sb.pop_front();
      vec++;
      if ({g0, m0, l0} !== {e0.g, e0.m, e0.l}) begin
        err++;
        $display("FAIL rr_rotate rr step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g0, m0, l0, e0.g, e0.m, e0.l);
      end
      vec++;
      if ({g1, m1, l1} !== {e1.g, e1.m, e1.l}) begin
        err++;
        $display("FAIL rr_rotate fix step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g1, m1, l1, e1.g, e1.m, e1.l);
      end
      vec++;
      if (g0 !== rot[j] || g1 !== 4'b0001) begin
        err++;
        $display("FAIL rr_rotate_const step %0d: got rr=%b fix=%b want rr=%b fix=0001", j, g0, g1, rot[j]);
      end
    end
  endtask

  task automatic test_lock;
    stim_t v[$];
    exp_t  e0, e1;
    v.push_back(mk(1, 4'b0100, 4'b0000, 1, HRESP_OKAY, 4'b0000));
    for (int j = 0; j < 5; j++) v.push_back(mk(1, 4'b1111, 4'b0100, 1, HRESP_OKAY, 4'b0000));
    v.push_back(mk(1, 4'b1111, 4'b0000, 1, HRESP_OKAY, 4'b0000));
    foreach (v[j]) begin
      step(v[j]);
      e0 = sb.pop_front(); e1 = sb.pop_front();
      vec++;
      if ({g0, m0, l0} !== {e0.g, e0.m, e0.l}) begin
        err++;
        $display("FAIL lock rr step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g0, m0, l0, e0.g, e0.m, e0.l);
      end
      vec++;
      if ({g1, m1, l1} !== {e1.g, e1.m, e1.l}) begin
        err++;
        $display("FAIL lock fix step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g1, m1, l1, e1.g, e1.m, e1.l);
      end
      if (j >= 1 && j <= 5) begin
        vec++;
        if (g0 !== 4'b0100 || l0 !== 1'b1) begin
          err++;
          $display("FAIL lock_hold step %0d: got g=%b l=%b want g=0100 l=1", j, g0, l0);
        end
      end
      if (j == 6) begin
        vec++;
        if (g0 !== 4'b1000) begin
          err++;
          $display("FAIL lock_release: got g=%b want g=1000", g0);
        end
      end
    end
  endtask

  task automatic test_split;
    stim_t      v[$];
    exp_t       e0, e1;
    logic [3:0] chk[int];
    v.push_back(mk(1, 4'b0010, 4'b0000, 1, HRESP_OKAY,  4'b0000));
    v.push_back(mk(1, 4'b0010, 4'b0000, 1, HRESP_OKAY,  4'b0000));
    v.push_back(mk(1, 4'b0011, 4'b0000, 0, HRESP_SPLIT, 4'b0000));
    v.push_back(mk(1, 4'b0010, 4'b0000, 1, HRESP_OKAY,  4'b0000));
    v.push_back(mk(1, 4'b0010, 4'b0000, 1, HRESP_OKAY,  4'b0010));
    v.push_back(mk(1, 4'b0010, 4'b0000, 1, HRESP_OKAY,  4'b0000));
    v.push_back(mk(1, 4'b0010, 4'b0000, 0, HRESP_RETRY, 4'b0000));
    v.push_back(mk(1, 4'b0010, 4'b0000, 1, HRESP_ERROR, 4'b0000));
    v.push_back(mk(1, 4'b0010, 4'b0000, 0, HRESP_SPLIT, 4'b0010));
    v.push_back(mk(1, 4'b0010, 4'b0000, 1, HRESP_OKAY,  4'b0000));
    v.push_back(mk(1, 4'b0010, 4'b0000, 1, HRESP_OKAY,  4'b0010));
    v.push_back(mk(1, 4'b0010, 4'b0000, 1, HRESP_OKAY,  4'b0000));
    chk[2] = 4'b0001; chk[3] = 4'b0001; chk[5] = 4'b0010; chk[7] = 4'b0010;
    chk[8] = 4'b0001; chk[9] = 4'b0001; chk[11] = 4'b0010;
    foreach (v[j]) begin
      step(v[j]);
      e0 = sb.pop_front(); e1 = sb.pop_front();
      vec++;
      if ({g0, m0, l0} !== {e0.g, e0.m, e0.l}) begin
        err++;
        $display("FAIL split rr step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g0, m0, l0, e0.g, e0.m, e0.l);
      end
      vec++;
      if ({g1, m1, l1} !== {e1.g, e1.m, e1.l}) begin
        err++;
        $display("FAIL split fix step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g1, m1, l1, e1.g, e1.m, e1.l);
      end
      if (chk.exists(j)) begin
        vec++;
        if (g0 !== chk[j]) begin
          err++;
          $display("FAIL split_const step %0d: got g=%b want g=%b", j, g0, chk[j]);
        end
      end
    end
  endtask

  task automatic test_hready_hold;
    stim_t v[$];
    exp_t  e0, e1;
    v.push_back(mk(1, 4'b1000, 4'b0000, 0, HRESP_OKAY, 4'b0000));
    v.push_back(mk(1, 4'b0100, 4'b0000, 0, HRESP_OKAY, 4'b0000));
    v.push_back(mk(1, 4'b0001, 4'b0000, 0, HRESP_OKAY, 4'b0000));
    v.push_back(mk(1, 4'b0001, 4'b0000, 1, HRESP_OKAY, 4'b0000));
    foreach (v[j]) begin
      step(v[j]);
      e0 = sb.pop_front(); e1 = sb.pop_front();
      vec++;
      if ({g0, m0, l0} !== {e0.g, e0.m, e0.l}) begin
        err++;
        $display("FAIL hready_hold rr step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g0, m0, l0, e0.g, e0.m, e0.l);
      end
      vec++;
      if ({g1, m1, l1} !== {e1.g, e1.m, e1.l}) begin
        err++;
        $display("FAIL hready_hold fix step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g1, m1, l1, e1.g, e1.m, e1.l);
      end
      vec++;
      if (j < 3 && {g0, m0} !== {4'b0010, 4'd0}) begin
        err++;
        $display("FAIL hready_hold_const step %0d: got g=%b m=%0d want g=0010 m=0", j, g0, m0);
      end else if (j == 3 && {g0, m0} !== {4'b0001, 4'd1}) begin
        err++;
        $display("FAIL hready_resume: got g=%b m=%0d want g=0001 m=1", g0, m0);
      end
    end
  endtask

  task automatic test_reset_mid_lock;
    stim_t v[$];
    exp_t  e0, e1;
    v.push_back(mk(1, 4'b1000, 4'b0000, 1, HRESP_OKAY,  4'b0000));
    v.push_back(mk(1, 4'b1000, 4'b1000, 1, HRESP_OKAY,  4'b0000));
    v.push_back(mk(1, 4'b1000, 4'b1000, 1, HRESP_OKAY,  4'b0000));
    v.push_back(mk(0, 4'b1000, 4'b1000, 1, HRESP_OKAY,  4'b0000));
    v.push_back(mk(1, 4'b1000, 4'b1000, 1, HRESP_OKAY,  4'b0000));
    v.push_back(mk(1, 4'b1000, 4'b0000, 1, HRESP_OKAY,  4'b0000));
    v.push_back(mk(1, 4'b1000, 4'b0000, 0, HRESP_SPLIT, 4'b0000));
    v.push_back(mk(0, 4'b1000, 4'b0000, 1, HRESP_OKAY,  4'b0000));
    v.push_back(mk(1, 4'b1000, 4'b0000, 1, HRESP_OKAY,  4'b0000));
    foreach (v[j]) begin
      step(v[j]);
      e0 = sb.pop_front(); e1 = sb.pop_front();
      vec++;
      if ({g0, m0, l0} !== {e0.g, e0.m, e0.l}) begin
        err++;
        $display("FAIL reset_mid rr step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g0, m0, l0, e0.g, e0.m, e0.l);
      end
      vec++;
      if ({g1, m1, l1} !== {e1.g, e1.m, e1.l}) begin
        err++;
        $display("FAIL reset_mid fix step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g1, m1, l1, e1.g, e1.m, e1.l);
      end
      if (j == 3) begin
        vec++;
        if ({g0, l0} !== {4'b0001, 1'b0}) begin
          err++;
          $display("FAIL reset_mid_lock: got g=%b l=%b want g=0001 l=0", g0, l0);
        end
      end
      if (j == 8) begin
        vec++;
        if (g0 !== 4'b1000) begin
          err++;
          $display("FAIL reset_mid_split: got g=%b want g=1000", g0);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    stim_t s;
    exp_t  e0, e1;
    for (int j = 0; j < 80; j++) begin
      s.rst  = ($urandom_range(0, 24) != 0);
      s.req  = 4'($urandom_range(0, 15));
      s.lk   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      s.rdy  = ($urandom_range(0, 3) != 0);
      s.resp = 2'($urandom_range(0, 3));
      s.spl  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      step(s);
      e0 = sb.pop_front(); e1 = sb.pop_front();
      vec++;
      if ({g0, m0, l0} !== {e0.g, e0.m, e0.l}) begin
        err++;
        $display("FAIL back_to_back rr step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g0, m0, l0, e0.g, e0.m, e0.l);
      end
      vec++;
      if ({g1, m1, l1} !== {e1.g, e1.m, e1.l}) begin
        err++;
        $display("FAIL back_to_back fix step %0d: got g=%b m=%0d l=%b want g=%b m=%0d l=%b", j, g1, m1, l1, e1.g, e1.m, e1.l);
      end
    end
  endtask

  initial begin
    test_reset;
    test_rr_rotate;
    test_lock;
    test_split;
    test_hready_hold;
    test_reset_mid_lock;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
